// File: rtl/concat_pack_pkg.sv
// Shared constants, types and helpers for the narrow-to-wide beat packer.
// Lane k of a packed word occupies bits [k*IN_W +: IN_W]; lane 0 is the first beat.
package concat_pack_pkg;

    localparam int IN_W  = 4;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO);

    typedef logic [RATIO-1:0] lane_keep_t;
    typedef logic [OUT_W-1:0] word_t;
    typedef logic [CW-1:0]    lane_idx_t;

    // Fill state is implicit in the lane counter: IDLE means no beat of the word taken yet.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    function automatic int lane_lsb(input lane_idx_t k);
        return int'(k) * IN_W;
    endfunction

    function automatic lane_idx_t clamp_ratio(input lane_idx_t r);
        if (int'(r) > RATIO - 1) begin
            return lane_idx_t'(RATIO - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/concat_pack_ctrl_out_stage.sv
// Output register of the packer: loads a finished word, holds it under backpressure,
// and tells the input side whether a beat may be accepted this cycle.
module pack_out_stage
    import concat_pack_pkg::*;
(
    input  logic             clk,
    input  logic             arst,
    input  logic             load,
    input  logic [OUT_W-1:0] load_data,
    input  logic [RATIO-1:0] load_keep,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [RATIO-1:0] out_keep,
    output logic             out_last,
    output logic             in_ready
);

    // A beat may only be taken when the register is empty or draining this cycle,
    // so a completion can never overwrite a word the consumer has not seen.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_last  <= load_last;
        end else if (out_ready) begin
            // Payload keeps its last value after the drain; only the valid flag drops.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/concat_pack_ctrl.sv
// Packs up to RATIO narrow beats into one wide word, first beat in the low lane.
// The lanes-per-word setting is latched on the first beat and held for the whole word.
module concat_pack_ctrl
    import concat_pack_pkg::*;
(
    input  logic             clk,
    input  logic             arst,
    input  logic [CW-1:0]    cfg_ratio,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [RATIO-1:0] out_keep,
    output logic             out_last
);

    lane_idx_t   cnt;
    lane_idx_t   cnt_d;
    lane_idx_t   ratio_q;
    lane_idx_t   ratio_d;
    lane_idx_t   eff;
    word_t       acc;
    word_t       acc_d;
    word_t       merged_data;
    lane_keep_t  acc_keep;
    lane_keep_t  keep_d;
    lane_keep_t  merged_keep;
    fill_state_e state;
    logic        accept;
    logic        complete;

    assign state  = (cnt == '0) ? IDLE : FILL;
    assign accept = in_valid && in_ready;
    // The first beat sees cfg_ratio directly so a 1-lane word needs no extra cycle.
    assign eff    = (state == IDLE) ? clamp_ratio(cfg_ratio) : ratio_q;

    // State register.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            cnt      <= '0;
            ratio_q  <= '0;
            acc      <= '0;
            acc_keep <= '0;
        end else begin
            cnt      <= cnt_d;
            ratio_q  <= ratio_d;
            acc      <= acc_d;
            acc_keep <= keep_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal is given its hold value first, so no path through the
        // branches below leaves one unassigned and no latch is inferred.
        cnt_d   = cnt;
        ratio_d = ratio_q;
        acc_d   = acc;
        keep_d  = acc_keep;
        if (accept) begin
            if (state == IDLE) begin
                ratio_d = eff;
            end
            if (complete) begin
                cnt_d  = '0;
                acc_d  = '0;
                keep_d = '0;
            end else begin
                cnt_d  = cnt + lane_idx_t'(1);
                acc_d  = merged_data;
                keep_d = merged_keep;
            end
        end
    end

    // Output logic: the current beat merged into its lane, and the completion decision.
    always_comb begin
        merged_data = acc | (word_t'(in_data) << lane_lsb(cnt));
        merged_keep = acc_keep | (lane_keep_t'(1) << cnt);
        complete    = accept && ((cnt == eff) || in_last);
    end

    pack_out_stage u_out_stage (
        .clk       (clk),
        .arst      (arst),
        .load      (complete),
        .load_data (merged_data),
        .load_keep (merged_keep),
        .load_last (in_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .in_ready  (in_ready)
    );

endmodule

// File: tb/tb_concat_pack_ctrl.sv
// Scoreboard bench for concat_pack_ctrl: a lane-list reference model predicts each
// packed word; a negedge monitor compares every word the DUT hands over.
module tb_concat_pack_ctrl;
    import concat_pack_pkg::*;

    logic             clk = 1'b0;
    logic             arst;
    logic [CW-1:0]    cfg_ratio;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic [RATIO-1:0] out_keep;
    logic             out_last;

    concat_pack_ctrl dut (
        .clk       (clk),
        .arst      (arst),
        .cfg_ratio (cfg_ratio),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] keep;
        logic             last;
        int               due;
    } exp_t;

    exp_t exp_q[$];
    int   cur[$];
    int   cur_eff;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   stalls = 0;
    bit   rand_ready  = 1'b0;
    bit   ready_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: collect beats of the current word as a list, emit when the
    // list reaches the word's lane count or the beat carries last.
    task automatic model_accept(input int d, input bit last, input int cfg);
        exp_t e;
        if (cur.size() == 0) cur_eff = (cfg > RATIO - 1) ? RATIO - 1 : cfg;
        cur.push_back(d);
        if (last || cur.size() == cur_eff + 1) begin
            e.data = '0;
            foreach (cur[k]) e.data = e.data | (OUT_W'(cur[k]) << (IN_W * k));
            e.keep = RATIO'((1 << cur.size()) - 1);
            e.last = last;
            e.due  = cyc;
            exp_q.push_back(e);
            cur.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat is taken.
    task automatic send(input int d, input bit last, input int cfg);
        bit rdy;
        int waited = 0;
        in_valid  = 1'b1;
        in_data   = IN_W'(d);
        in_last   = last;
        cfg_ratio = CW'(cfg);
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (!rdy) begin
                stalls++;
                waited++;
            end
        end while (!rdy && waited < 200);
        if (!rdy) check("send_accept", 32'(rdy), 32'd1);
        else model_accept(d, last, cfg);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: latency of each newly presented word, hold stability, and scoreboard pops.
    bit               prev_stall = 1'b0;
    logic [OUT_W-1:0] held_data;
    logic [RATIO-1:0] held_keep;
    logic             held_last;

    always @(negedge clk) begin
        if (!arst) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (prev_stall) begin
                    check("hold_data", 32'(out_data), 32'(held_data));
                    check("hold_keep", 32'(out_keep), 32'(held_keep));
                    check("hold_last", 32'(out_last), 32'(held_last));
                end else if (exp_q.size() > 0) begin
                    check("latency", 32'(cyc), 32'(exp_q[0].due));
                end
                if (out_ready) begin
                    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_keep", 32'(out_keep), 32'(e.keep));
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                end
                prev_stall = !out_ready;
                held_data  = out_data;
                held_keep  = out_keep;
                held_last  = out_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_keep"},  32'(out_keep),  32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    initial begin
        arst      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        cfg_ratio = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        #1;

        // Full 4-lane word, then an early-closed word and another full word.
        for (int i = 1; i <= 4; i++) send(i, 1'b0, 3);
        idle(3);
        check("drained_after_word", 32'(out_valid), 32'd0);
        send(4'hA, 1'b0, 3);
        send(4'hB, 1'b1, 3);
        for (int i = 5; i <= 8; i++) send(i, 1'b0, 3);
        idle(3);

        // Two-lane words, and a cfg change mid-word that must be ignored.
        for (int i = 1; i <= 4; i++) send(i, 1'b0, 1);
        idle(2);
        send(1, 1'b0, 1);
        send(2, 1'b0, 3);
        idle(3);

        // Backpressure: hold out_ready low while a word sits in the output register.
        ready_force = 1'b0;
        idle(2);
        fork
            begin
                for (int i = 1; i <= 8; i++) send(i, 1'b0, 3);
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                check("stall_word_seen", 32'(out_valid), 32'd1);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                end
                ready_force = 1'b1;
            end
        join
        idle(3);

        // Sixteen back-to-back beats must flow without a single stall.
        stalls = 0;
        for (int i = 0; i < 16; i++) send(i, 1'b0, 3);
        check("no_bubble_16", 32'(stalls), 32'd0);
        idle(3);

        // One-lane words every cycle: each drain coincides with the next load.
        stalls = 0;
        for (int i = 0; i < 6; i++) send($urandom_range(0, 15), 1'b0, 0);
        check("no_bubble_eff0", 32'(stalls), 32'd0);
        send(4'h7, 1'b1, 2);
        for (int i = 1; i <= 4; i++) send(i, (i == 4), 3);
        idle(3);

        // Reset mid-word: the partial word is dropped.
        send(1, 1'b0, 3);
        send(2, 1'b0, 3);
        arst = 1'b0;
        cur.delete();
        #1;
        check_reset_outputs("midword_reset");
        @(negedge clk);
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 9; i >= 6; i--) send(i, 1'b0, 3);
        idle(3);

        // Randomized traffic with random backpressure, gaps, cfg and early closes.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send($urandom_range(0, 15), ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
        if (cur.size() > 0) send($urandom_range(0, 15), 1'b1, 0);
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) idle(1);
        idle(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/concat_pack_ctrl.md
Name: concat_pack_ctrl

Overview:
Sequencing controller for the slice/concat datapath. Accepts a stream of narrow IN_W-bit beats and concatenates up to RATIO consecutive beats into one OUT_W-bit word, with the first beat in the least-significant lane (concat in0 = low bits). Ratio is runtime-configurable per word. Sits between a narrow producer and a wide consumer, with valid/ready handshakes on both sides.

Parameters:
IN_W, 4, width of one input beat / lane
RATIO, 4, maximum lanes per output word (>=2); OUT_W = IN_W*RATIO
CW, $clog2(RATIO), width of lane counter and cfg_ratio

Ports:
clk  in  1  clock, rising edge
arst  in  1  asynchronous reset, active-low
cfg_ratio  in  CW  lanes per word minus 1; sampled only on the first beat of a word
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_data  in  IN_W  input beat
in_last  in  1  closes the current word early (partial word)
out_valid  out  1  packed word valid
out_ready  in  1  consumer ready
out_data  out  OUT_W  packed word; lane k = bits [k*IN_W +: IN_W]
out_keep  out  RATIO  lane k holds valid data
out_last  out  1  word was closed by in_last

Behaviour:
- Reset (arst low, async): cnt=0, acc=0, acc_keep=0, ratio_q=0, out_valid=0, out_data=0, out_keep=0, out_last=0. Any partial word is discarded; no output is produced for it after reset release.
- in_ready = !out_valid | out_ready (combinational). A beat is never accepted while the output register is stalled.
- Accept, cnt==0: ratio_q <= min(cfg_ratio, RATIO-1). The effective ratio is eff = that value, both on this beat and for the rest of the word.
- Every accept: lane cnt written with in_data and acc_keep[cnt] set.
- Word completion: the word completes when cnt==eff or in_last=1. On completion, next cycle: out_data = acc with the new lane merged; out_keep = acc_keep with the new bit; out_last = in_last; out_valid=1. Also cnt<=0, acc<=0, acc_keep<=0.
- Non-completing accept: cnt<=cnt+1.
- Latency: out_valid rises 1 cycle after the completing beat is accepted.
- Unused lanes are 0 with keep bit 0.
- Output hold: out_valid&!out_ready keeps out_data/keep/last stable.
- Output drain: out_valid&out_ready with no new completion clears out_valid. The outputs other than out_valid keep their last value.
- Drain and completion in the same cycle: the output register loads the new word and out_valid stays 1. Sustained throughput is 1 beat/cycle with no bubbles.
- eff=0 (cfg_ratio=0): every beat is its own word, keep=0b0001.
- in_last on the first beat: a 1-lane word.
- in_last on lane eff: a full word with out_last=1.
- cfg_ratio changes mid-word: ignored until the next word.
- cfg_ratio > RATIO-1: clamped to RATIO-1.
- cnt wrap: never exceeds eff. cnt returns to 0 only via completion or reset.

Decomposition:
- Package concat_pack_pkg holds:
  - the lane-index function (k*IN_W offset);
  - localparams OUT_W and CW;
  - typedef lane_keep_t (RATIO bits).
- One sub-module is natural: pack_out_stage. It is the output register with the valid/ready hold, the load-on-complete logic and the in_ready generation.
- The FSM stays in the top level. It is implicit in cnt: IDLE when cnt==0, FILL otherwise.

Test Plan:
- IN_W=4, RATIO=4, cfg_ratio=3, out_ready=1; beats 1,2,3,4 on consecutive cycles -> one cycle later out_data=0x4321, out_keep=0xF, out_last=0, for exactly 1 cycle.
- Beats A,B with in_last on B -> out_data=0x00BA, out_keep=0x3, out_last=1. Following beats 5,6,7,8 -> 0x8765, keep=0xF.
- cfg_ratio=1; beats 1..4 continuous -> two words, 0x0021 then 0x0043, keep=0x3, out_valid on alternate cycles. Changing cfg_ratio to 3 after beat 1 -> still 0x0021.
- Hold out_ready=0 after word 0x4321 -> out_data stable and in_ready=0 for 5 cycles, no beats lost. Then out_ready=1 with the next word completing in the same cycle -> back-to-back out_valid, second word correct.
- 16 back-to-back beats 0..F with out_ready=1 -> in_ready never drops; outputs 0x3210, 0x7654, 0xBA98, 0xFEDC.
- Assert arst after beats 1,2 (mid-word), release, send 9,8,7,6 -> only 0x6789 emitted; all outputs 0 during reset.
